slave_read: RTL and testbench
=============================

SLAVE_READ -- requirements
Module: slave_read

Interface
REQ-001 Parameter MEM_AW, default 14, word-address width of the attached synchronous SRAM (64 KiB at 14).
REQ-002 Parameter ID_W, default `AXI_ID_BITS (4), width of ARID/RID.
REQ-003 ACLK  input  1  sole clock; all state changes on posedge ACLK.
REQ-004 ARESET  input  1  synchronous, active-high reset.
REQ-005 ARID  input  ID_W  read transaction ID.
REQ-006 ARADDR  input  32  byte start address.
REQ-007 ARLEN  input  4  beats minus one (1..16 beats).
REQ-008 ARSIZE  input  3  beat size; only 3'b010 (4 bytes) legal.
REQ-009 ARBURST  input  2  burst type.
REQ-010 ARVALID  input  1  / ARREADY  output  1  address handshake pair.
REQ-011 RID  output  ID_W  / RDATA  output  32  / RRESP  output  2  / RLAST  output  1  read-data beat fields.
REQ-012 RVALID  output  1  / RREADY  input  1  data handshake pair.
REQ-013 mem_cs  output  1  SRAM read strobe; mem_addr  output  MEM_AW  word address; mem_rdata  input  32  valid exactly one cycle after mem_cs.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, FETCH, DATA, ERR.
REQ-016 IDLE: ARREADY=1; on ARVALID latch ARID, ARADDR, ARLEN, ARSIZE, ARBURST, load beat counter=ARLEN; go FETCH if legal, else ERR.
REQ-017 ARREADY=0 in every state except IDLE; no second address accepted before RLAST handshake.
REQ-018 FETCH (one cycle): mem_cs=1, mem_addr=addr_q[MEM_AW+1:2]; next state DATA.
REQ-019 DATA: RVALID=1, RRESP=2'b00, RID=id_q, RLAST=(counter==0); RDATA=mem_rdata in first DATA cycle after mem_cs, else held register (captured from mem_rdata that cycle).
REQ-020 RDATA/RID/RLAST/RRESP stable while RVALID=1 and RREADY=0.
REQ-021 DATA handshake, not last: decrement counter, advance address, assert mem_cs same cycle with new address, stay DATA (1 beat/cycle when RREADY held high).
REQ-022 DATA handshake with RLAST: go IDLE; no mem_cs that cycle.
REQ-023 Burst latency: AR handshake at cycle T -> FETCH T+1 -> first RVALID T+2; N-beat burst with RREADY=1 completes at T+1+N.
REQ-024 INCR (2'b01): address += 4 per beat; mem_addr wraps modulo 2^MEM_AW, no error.
REQ-025 Illegal: ARSIZE!=3'b010, ARBURST FIXED(2'b00) or 2'b11, or WRAP when not enabled/invalid length (REQ-032).
REQ-026 ERR: RVALID=1, RDATA=0, RRESP=2'b10 (SLVERR), RID=id_q, full ARLEN+1 beats with correct RLAST; mem_cs never asserted; IDLE after RLAST handshake.
REQ-027 ARADDR[1:0] ignored (word aligned).

Reset
REQ-028 ARESET=1 at posedge: state IDLE, counter 0, address/ID/data registers 0.
REQ-029 Outputs during/after reset: ARREADY=1 (IDLE), RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, mem_cs=0, mem_addr=0, busy=0.
REQ-030 Reset mid-burst: aborts at that edge; RVALID=0 next cycle; no further beats for aborted ID.

Configuration
REQ-031 Macro SLAVE_READ_WRAP_EN compiles WRAP burst support in.
REQ-032 Defined: ARBURST=2'b10 with ARLEN in {1,3,7,15} legal; address increments by 4 within aligned window of (ARLEN+1)*4 bytes, wrapping to window base; other ARLEN with WRAP -> ERR.
REQ-033 Undefined: ARBURST=2'b10 always -> ERR.

Structure
REQ-034 Shared package axi_pkg: burst constants (FIXED/INCR/WRAP), RRESP constants (OKAY/SLVERR), SIZE_4B, state enum type.
REQ-035 One sub-module natural: slave_read_addr_gen (next-address computation, INCR/WRAP); all else in slave_read.

Verification
REQ-036 INCR ARADDR=0x0000_0010, ARLEN=3, RREADY=1, mem preset word[4..7]=A..D -> RDATA A,B,C,D on four consecutive cycles, RLAST on 4th, first RVALID 2 cycles after AR handshake.
REQ-037 Same burst, RREADY low 3 cycles on beat 2 -> RDATA=B held stable, mem_cs not reasserted until handshake, sequence unchanged.
REQ-038 ARSIZE=3'b001, ARLEN=1, ARID=5 -> two beats RRESP=2'b10, RDATA=0, RID=5, mem_cs never high.
REQ-039 With SLAVE_READ_WRAP_EN, ARBURST=WRAP, ARADDR=0x38, ARLEN=3 -> mem_addr 14,15,12,13; without macro -> 4 SLVERR beats.
REQ-040 ARESET pulsed during beat 2 of 4-beat burst -> RVALID=0 next cycle, ARREADY=1, new burst then completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants and the slave_read state type.
// Also provides the default ID width macro AXI_ID_BITS when not set by the build.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_ERR   = 2'd3
  } rd_state_t;

  // WRAP bursts need a power-of-two beat count of 2, 4, 8 or 16.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/slave_read_addr_gen.sv
// Next word-address computation for INCR and WRAP read bursts.
// Works on word addresses, so wrap at the top of the SRAM falls out of the width.
module slave_read_addr_gen
  import axi_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic [MEM_AW-1:0] waddr_i,
  input  logic [1:0]        burst_i,
  input  logic [3:0]        len_i,
  output logic [MEM_AW-1:0] waddr_next_o
);

  logic [MEM_AW-1:0] inc_s;
  logic [MEM_AW-1:0] mask_s;

  // A legal WRAP length (beats-1) is already the in-window word mask.
  always_comb begin
    inc_s  = waddr_i + {{(MEM_AW-1){1'b0}}, 1'b1};
    mask_s = {{(MEM_AW-4){1'b0}}, len_i};
    if (burst_i == BURST_WRAP) begin
      waddr_next_o = (waddr_i & ~mask_s) | (inc_s & mask_s);
    end else begin
      waddr_next_o = inc_s;
    end
  end

endmodule

// File: rtl/slave_read.sv
// AXI read-only slave in front of a synchronous single-cycle SRAM.
// Define SLAVE_READ_WRAP_EN to accept WRAP bursts; otherwise they answer SLVERR.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module slave_read
  import axi_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int ID_W   = `AXI_ID_BITS
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              mem_cs,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  rd_state_t         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [MEM_AW-1:0] waddr_next_s;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fresh_q, fresh_d;
  logic              wrap_ok_s;
  logic              legal_s;
  logic              unused_addr_s;

  // Byte-lane bits and bits above the SRAM window play no part in addressing.
  assign unused_addr_s = ^{ARADDR[31:MEM_AW+2], ARADDR[1:0]};

`ifdef SLAVE_READ_WRAP_EN
  assign wrap_ok_s = (ARBURST == BURST_WRAP) && wrap_len_ok(ARLEN);
`else
  assign wrap_ok_s = 1'b0;
`endif

  assign legal_s = (ARSIZE == SIZE_4B) && ((ARBURST == BURST_INCR) || wrap_ok_s);

  slave_read_addr_gen #(
    .MEM_AW (MEM_AW)
  ) u_addr_gen (
    .waddr_i      (waddr_q),
    .burst_i      (burst_q),
    .len_i        (len_q),
    .waddr_next_o (waddr_next_s)
  );

  // State, burst context and beat data registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      len_q   <= 4'd0;
      burst_q <= 2'b00;
      waddr_q <= '0;
      id_q    <= '0;
      rdata_q <= 32'd0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      waddr_q <= waddr_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      fresh_q <= fresh_d;
    end
  end

  // Next-state and output decode; fresh_q marks the cycle SRAM data is live.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    burst_d  = burst_q;
    waddr_d  = waddr_q;
    id_d     = id_q;
    rdata_d  = fresh_q ? mem_rdata : rdata_q;
    fresh_d  = 1'b0;
    ARREADY  = 1'b0;
    RVALID   = 1'b0;
    RID      = '0;
    RDATA    = 32'd0;
    RRESP    = RESP_OKAY;
    RLAST    = 1'b0;
    mem_cs   = 1'b0;
    mem_addr = waddr_q;
    busy     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        ARREADY = 1'b1;
        busy    = 1'b0;
        if (ARVALID) begin
          id_d    = ARID;
          waddr_d = ARADDR[MEM_AW+1:2];
          len_d   = ARLEN;
          cnt_d   = ARLEN;
          burst_d = ARBURST;
          state_d = legal_s ? ST_FETCH : ST_ERR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_cs  = 1'b1;
        fresh_d = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        RVALID = 1'b1;
        RID    = id_q;
        RLAST  = (cnt_q == 4'd0);
        RDATA  = fresh_q ? mem_rdata : rdata_q;
        if (RREADY) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            // Prefetch the next beat in the handshake cycle for 1 beat/cycle.
            cnt_d    = cnt_q - 4'd1;
            waddr_d  = waddr_next_s;
            mem_cs   = 1'b1;
            mem_addr = waddr_next_s;
            fresh_d  = 1'b1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_ERR: begin
        RVALID = 1'b1;
        RID    = id_q;
        RRESP  = RESP_SLVERR;
        RLAST  = (cnt_q == 4'd0);
        if (RREADY) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_slave_read.sv
// Directed, table-driven bench for slave_read with a behavioural SRAM.
// Expectations follow SLAVE_READ_WRAP_EN the same way the design does.
module tb_slave_read;

  localparam int MEM_AW = 14;
  localparam int ID_W   = 4;
`ifdef SLAVE_READ_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [ID_W-1:0]   ARID;
  logic [31:0]       ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              mem_cs;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              busy;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err;
    logic        wrap;
    logic [13:0] w0;
  } vec_t;

  vec_t vecs [0:9];

  slave_read #(.MEM_AW(MEM_AW), .ID_W(ID_W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  // Read data is only meaningful the cycle after a strobe; poison it otherwise.
  always @(posedge ACLK) mem_rdata <= mem_cs ? mem[mem_addr] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] beat_word(input vec_t v, input int k);
    int n, w, base;
    n = int'(v.len) + 1;
    w = int'(v.w0);
    if (v.wrap) begin
      base = (w / n) * n;
      beat_word = 14'(base + ((w - base + k) % n));
    end else begin
      beat_word = 14'((w + k) % 16384);
    end
  endfunction

  task automatic run_burst(input vec_t v, input int stall_beat, input int reset_beat);
    int wait_n;
    logic [31:0] exp_d;
    @(negedge ACLK);
    ARVALID = 1'b1; ARID = v.id; ARADDR = v.addr; ARLEN = v.len;
    ARSIZE = v.size; ARBURST = v.burst; RREADY = 1'b1;
    wait_n = 0;
    while (ARREADY !== 1'b1 && wait_n < 20) begin
      @(negedge ACLK);
      wait_n++;
    end
    chk("ar_ready_wait", {31'd0, ARREADY}, 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    #1;
    if (!v.err) begin
      chk("fetch_rvalid", {31'd0, RVALID}, 32'd0);
      chk("fetch_cs", {31'd0, mem_cs}, 32'd1);
      chk("fetch_addr", {18'd0, mem_addr}, {18'd0, beat_word(v, 0)});
      chk("fetch_arready", {31'd0, ARREADY}, 32'd0);
      chk("fetch_busy", {31'd0, busy}, 32'd1);
      @(negedge ACLK);
      #1;
    end
    for (int k = 0; k <= int'(v.len); k++) begin
      exp_d = v.err ? 32'd0 : mem[beat_word(v, k)];
      if (k == reset_beat) begin
        chk("pre_rst_rdata", RDATA, exp_d);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
          chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
          chk("rst_arready", {31'd0, ARREADY}, 32'd1);
          chk("rst_busy", {31'd0, busy}, 32'd0);
          chk("rst_cs", {31'd0, mem_cs}, 32'd0);
          @(negedge ACLK);
          #1;
        end
        return;
      end
      if (k == stall_beat) begin
        RREADY = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
          chk("stall_rvalid", {31'd0, RVALID}, 32'd1);
          chk("stall_rdata", RDATA, exp_d);
          chk("stall_rlast", {31'd0, RLAST}, {31'd0, k == int'(v.len)});
          chk("stall_cs", {31'd0, mem_cs}, 32'd0);
          @(negedge ACLK);
          #1;
        end
        RREADY = 1'b1;
        #1;
      end
      chk("beat_rvalid", {31'd0, RVALID}, 32'd1);
      chk("beat_rdata", RDATA, exp_d);
      chk("beat_rresp", {30'd0, RRESP}, v.err ? 32'd2 : 32'd0);
      chk("beat_rid", {28'd0, RID}, {28'd0, v.id});
      chk("beat_rlast", {31'd0, RLAST}, {31'd0, k == int'(v.len)});
      chk("beat_arready", {31'd0, ARREADY}, 32'd0);
      if (!v.err && k != int'(v.len)) begin
        chk("beat_cs", {31'd0, mem_cs}, 32'd1);
        chk("beat_addr", {18'd0, mem_addr}, {18'd0, beat_word(v, k + 1)});
      end else begin
        chk("beat_cs", {31'd0, mem_cs}, 32'd0);
      end
      @(negedge ACLK);
      #1;
    end
    chk("done_rvalid", {31'd0, RVALID}, 32'd0);
    chk("done_arready", {31'd0, ARREADY}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[4] = 32'hAAAA_AAAA;
    mem[5] = 32'hBBBB_BBBB;
    mem[6] = 32'hCCCC_CCCC;
    mem[7] = 32'hDDDD_DDDD;

    //          id     addr           len    size    burst  err                     wrap     w0
    vecs[0] = '{4'd3,  32'h0000_0010, 4'd3,  3'b010, 2'b01, 1'b0,                   1'b0,    14'd4};
    vecs[1] = '{4'd5,  32'h0000_0100, 4'd1,  3'b001, 2'b01, 1'b1,                   1'b0,    14'd64};
    vecs[2] = '{4'd1,  32'h0000_0038, 4'd3,  3'b010, 2'b10, WRAP_ON ? 1'b0 : 1'b1,  WRAP_ON, 14'd14};
    vecs[3] = '{4'd2,  32'h0000_FFF3, 4'd7,  3'b010, 2'b01, 1'b0,                   1'b0,    14'd16380};
    vecs[4] = '{4'd7,  32'hABCD_0040, 4'd0,  3'b010, 2'b01, 1'b0,                   1'b0,    14'd16};
    vecs[5] = '{4'd9,  32'h0000_0040, 4'd2,  3'b010, 2'b00, 1'b1,                   1'b0,    14'd16};
    vecs[6] = '{4'd4,  32'h0000_0080, 4'd1,  3'b010, 2'b11, 1'b1,                   1'b0,    14'd32};
    vecs[7] = '{4'd6,  32'h0000_0038, 4'd2,  3'b010, 2'b10, 1'b1,                   1'b0,    14'd14};
    vecs[8] = '{4'd15, 32'h0000_0200, 4'd15, 3'b010, 2'b01, 1'b0,                   1'b0,    14'd128};
    vecs[9] = '{4'd8,  32'h0000_0104, 4'd7,  3'b010, 2'b10, WRAP_ON ? 1'b0 : 1'b1,  WRAP_ON, 14'd65};

    ARESET = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = 32'd0; ARLEN = 4'd0;
    ARSIZE = 3'b010; ARBURST = 2'b01; RREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("rst_hold_rvalid", {31'd0, RVALID}, 32'd0);
    chk("rst_hold_arready", {31'd0, ARREADY}, 32'd1);
    ARESET = 1'b0;
    @(negedge ACLK);
    #1;
    chk("reset_arready", {31'd0, ARREADY}, 32'd1);
    chk("reset_rvalid", {31'd0, RVALID}, 32'd0);
    chk("reset_rlast", {31'd0, RLAST}, 32'd0);
    chk("reset_rresp", {30'd0, RRESP}, 32'd0);
    chk("reset_rid", {28'd0, RID}, 32'd0);
    chk("reset_rdata", RDATA, 32'd0);
    chk("reset_cs", {31'd0, mem_cs}, 32'd0);
    chk("reset_addr", {18'd0, mem_addr}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) run_burst(vecs[i], -1, -1);

    // Back-pressure on beat 2, and on the first beat of an error burst.
    run_burst(vecs[0], 1, -1);
    run_burst(vecs[1], 0, -1);
    // Reset during beat 2, then the same burst again from scratch.
    run_burst(vecs[0], -1, 1);
    run_burst(vecs[0], -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
